// File: rtl/cpu_mem_arbiter_if.sv
// rtl/cpu_mem_arbiter_if.sv - pipeline/memory bus bundle shared by the arbiter and its environment
interface cpu_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4
);
    logic                  adv;
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [MASK_WIDTH-1:0] i_mask;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_stall;
    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [MASK_WIDTH-1:0] d_mask;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_stall;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [MASK_WIDTH-1:0] mem_mask;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport slave (
        input  adv, i_read, i_addr, i_mask, d_read, d_write, d_addr, d_mask, d_wdata,
               mem_rdata, mem_ack,
        output i_rdata, i_stall, d_rdata, d_stall,
               mem_req, mem_we, mem_addr, mem_mask, mem_wdata
    );

    modport master (
        output adv, i_read, i_addr, i_mask, d_read, d_write, d_addr, d_mask, d_wdata,
               mem_rdata, mem_ack,
        input  i_rdata, i_stall, d_rdata, d_stall,
               mem_req, mem_we, mem_addr, mem_mask, mem_wdata
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - shares one memory port between instruction-fetch and data masters
module cpu_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    cpu_mem_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t                state;
    logic                  done_i, done_d;
    logic [DATA_WIDTH-1:0] held_i, held_d;

    logic i_req, d_req, ack_i, ack_d;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;
    assign ack_i = (state == BUSY_I) && bus.mem_ack;
    assign ack_d = (state == BUSY_D) && bus.mem_ack;

    assign bus.i_stall = i_req & ~done_i & ~ack_i;
    assign bus.d_stall = d_req & ~done_d & ~ack_d;

    // A held result takes precedence; otherwise data is visible only in the ack cycle.
    always_comb begin
        bus.i_rdata = '0;
        bus.d_rdata = '0;
        if (done_i)
            bus.i_rdata = held_i;
        else if (ack_i)
            bus.i_rdata = bus.mem_rdata;
        if (done_d)
            bus.d_rdata = held_d;
        else if (ack_d && !bus.mem_we)
            bus.d_rdata = bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_mask  <= '0;
            bus.mem_wdata <= '0;
            done_i        <= 1'b0;
            done_d        <= 1'b0;
            held_i        <= '0;
            held_d        <= '0;
        end else begin
            if (bus.adv) begin
                done_i <= 1'b0;
                done_d <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (d_req && !done_d) begin
                        state         <= BUSY_D;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.d_write;
                        bus.mem_addr  <= bus.d_addr;
                        bus.mem_mask  <= bus.d_mask;
                        bus.mem_wdata <= bus.d_wdata;
                    end else if (i_req && !done_i) begin
                        state         <= BUSY_I;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= bus.i_addr;
                        bus.mem_mask  <= bus.i_mask;
                        bus.mem_wdata <= '0;
                    end else begin
                        bus.mem_req   <= 1'b0;
                    end
                end
                BUSY_I: begin
                    if (bus.mem_ack) begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                        // A flushed request (dropped mid-access) discards its result.
                        if (i_req && !bus.adv) begin
                            done_i <= 1'b1;
                            held_i <= bus.mem_rdata;
                        end
                    end
                end
                BUSY_D: begin
                    if (bus.mem_ack) begin
                        state       <= IDLE;
                        bus.mem_req <= 1'b0;
                        if (d_req && !bus.adv) begin
                            done_d <= 1'b1;
                            held_d <= bus.mem_we ? '0 : bus.mem_rdata;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - directed self-checking bench for cpu_mem_arbiter
module tb_cpu_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    cpu_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(4)) bus ();

    cpu_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.adv       = 1'b0;
        bus.i_read    = 1'b0;
        bus.i_addr    = '0;
        bus.i_mask    = 4'hf;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_addr    = '0;
        bus.d_mask    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
        tick();
        tick();
        settle();
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_i_stall", bus.i_stall, 0);
        check("rst_d_stall", bus.d_stall, 0);
        check("rst_i_rdata", bus.i_rdata, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        rst = 1'b0;

        // Single instruction read, ack one cycle after mem_req rises
        tick();
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_1000;
        settle();
        check("t1_i_stall_idle", bus.i_stall, 1);
        check("t1_mem_req_idle", bus.mem_req, 0);
        tick();
        settle();
        check("t1_mem_req", bus.mem_req, 1);
        check("t1_mem_addr", bus.mem_addr, 32'h0000_1000);
        check("t1_mem_we", bus.mem_we, 0);
        check("t1_i_stall_busy", bus.i_stall, 1);
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h2402_0005;
        bus.adv       = 1'b1;
        settle();
        check("t1_i_stall_ack", bus.i_stall, 0);
        check("t1_i_rdata_ack", bus.i_rdata, 32'h2402_0005);
        tick();
        bus.mem_ack = 1'b0;
        bus.adv     = 1'b0;
        bus.i_read  = 1'b0;
        settle();
        check("t1_mem_req_after", bus.mem_req, 0);
        check("t1_i_rdata_after", bus.i_rdata, 0);

        // Concurrent write and instruction read: data first, no repeated write
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h80;
        bus.d_mask  = 4'b0011;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.i_read  = 1'b1;
        bus.i_addr  = 32'h1004;
        settle();
        check("t2_d_stall", bus.d_stall, 1);
        check("t2_i_stall", bus.i_stall, 1);
        tick();
        settle();
        check("t2_mem_req_d", bus.mem_req, 1);
        check("t2_mem_we_d", bus.mem_we, 1);
        check("t2_mem_addr_d", bus.mem_addr, 32'h80);
        check("t2_mem_mask_d", bus.mem_mask, 4'b0011);
        check("t2_mem_wdata_d", bus.mem_wdata, 32'hDEAD_BEEF);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h7777_7777;
        settle();
        check("t2_d_stall_ack", bus.d_stall, 0);
        check("t2_d_rdata_wr", bus.d_rdata, 0);
        tick();
        bus.mem_ack = 1'b0;
        settle();
        check("t2_mem_req_gap", bus.mem_req, 0);
        check("t2_d_stall_done", bus.d_stall, 0);
        check("t2_i_stall_wait", bus.i_stall, 1);
        tick();
        settle();
        check("t2_mem_req_i", bus.mem_req, 1);
        check("t2_mem_we_i", bus.mem_we, 0);
        check("t2_mem_addr_i", bus.mem_addr, 32'h1004);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h8C44_0000;
        settle();
        check("t2_i_rdata_ack", bus.i_rdata, 32'h8C44_0000);
        check("t2_i_stall_ack", bus.i_stall, 0);
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        settle();
        check("t2_i_rdata_held", bus.i_rdata, 32'h8C44_0000);
        check("t2_i_stall_done", bus.i_stall, 0);
        check("t2_d_stall_done2", bus.d_stall, 0);
        tick();
        settle();
        check("t2_no_reissue", bus.mem_req, 0);
        bus.adv = 1'b1;
        tick();
        settle();
        check("t2_d_done_cleared", bus.d_stall, 1);
        check("t2_i_done_cleared", bus.i_stall, 1);
        check("t2_i_rdata_cleared", bus.i_rdata, 0);
        bus.adv     = 1'b0;
        bus.d_write = 1'b0;
        bus.i_read  = 1'b0;
        tick();
        settle();
        check("t2_idle_req", bus.mem_req, 0);

        // Held data result survives while instruction master still stalls
        bus.d_read = 1'b1;
        bus.d_addr = 32'h40;
        bus.i_read = 1'b1;
        bus.i_addr = 32'h2000;
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        settle();
        check("t3_d_rdata_ack", bus.d_rdata, 32'h1234_5678);
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        settle();
        check("t3_d_rdata_hold1", bus.d_rdata, 32'h1234_5678);
        check("t3_d_stall_hold", bus.d_stall, 0);
        check("t3_i_stall_hold", bus.i_stall, 1);
        tick();
        settle();
        check("t3_mem_addr_i", bus.mem_addr, 32'h2000);
        check("t3_d_rdata_hold2", bus.d_rdata, 32'h1234_5678);
        tick();
        settle();
        check("t3_d_rdata_hold3", bus.d_rdata, 32'h1234_5678);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hAAAA_5555;
        bus.adv       = 1'b1;
        settle();
        check("t3_i_rdata_ack", bus.i_rdata, 32'hAAAA_5555);
        check("t3_d_rdata_adv", bus.d_rdata, 32'h1234_5678);
        tick();
        bus.mem_ack = 1'b0;
        settle();
        check("t3_d_rdata_released", bus.d_rdata, 0);
        check("t3_i_rdata_released", bus.i_rdata, 0);
        bus.adv    = 1'b0;
        bus.d_read = 1'b0;
        bus.i_read = 1'b0;
        tick();

        // Zero-latency ack in the first mem_req cycle
        bus.d_read = 1'b1;
        bus.d_addr = 32'h44;
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0BAD_F00D;
        bus.adv       = 1'b1;
        settle();
        check("t4_d_rdata", bus.d_rdata, 32'h0BAD_F00D);
        check("t4_d_stall", bus.d_stall, 0);
        tick();
        bus.mem_ack = 1'b0;
        bus.adv     = 1'b0;
        bus.d_read  = 1'b0;
        settle();
        check("t4_mem_req", bus.mem_req, 0);

        // Flush: instruction request dropped while busy
        bus.i_read = 1'b1;
        bus.i_addr = 32'h3000;
        tick();
        bus.i_read = 1'b0;
        settle();
        check("t5_i_stall_flush", bus.i_stall, 0);
        tick();
        settle();
        check("t5_mem_req_held", bus.mem_req, 1);
        check("t5_mem_addr_held", bus.mem_addr, 32'h3000);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h55;
        tick();
        bus.mem_ack = 1'b0;
        settle();
        check("t5_mem_req_done", bus.mem_req, 0);
        check("t5_i_rdata_none", bus.i_rdata, 0);
        tick();
        settle();
        check("t5_no_reissue", bus.mem_req, 0);
        bus.i_read = 1'b1;
        settle();
        check("t5_done_i_clear", bus.i_stall, 1);
        tick();
        bus.mem_ack = 1'b1;
        bus.adv     = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        bus.adv     = 1'b0;
        bus.i_read  = 1'b0;
        tick();

        // Reset mid-access, then a stray ack
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h90;
        bus.d_wdata = 32'h0000_0099;
        tick();
        settle();
        check("t6_mem_req_busy", bus.mem_req, 1);
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        bus.d_write = 1'b0;
        settle();
        check("t6_mem_req_rst", bus.mem_req, 0);
        check("t6_mem_we_rst", bus.mem_we, 0);
        check("t6_mem_addr_rst", bus.mem_addr, 0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_0000;
        settle();
        check("t6_stray_d_rdata", bus.d_rdata, 0);
        tick();
        bus.mem_ack = 1'b0;
        settle();
        check("t6_stray_mem_req", bus.mem_req, 0);
        bus.d_read = 1'b1;
        bus.d_addr = 32'h94;
        settle();
        check("t6_no_done_d", bus.d_stall, 1);
        tick();
        settle();
        check("t6_issue_after", bus.mem_req, 1);
        check("t6_issue_addr", bus.mem_addr, 32'h94);
        bus.mem_ack = 1'b1;
        bus.adv     = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        bus.adv     = 1'b0;
        bus.d_read  = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch bus master and the data (MEM-stage) bus master.
- Arbitrates between them, holds the winning request stable until the memory acknowledges, and returns read data.
- Holds each master's completed result until the pipeline advances, so an access is never re-issued while the other master is still stalling.
- Sits between the IF/MEM stages and the memory/cache interface.

Parameters:
- ADDR_WIDTH, 32, width of physical address.
- DATA_WIDTH, 32, width of data bus.
- MASK_WIDTH, 4, byte-enable width (DATA_WIDTH/8).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- adv  in  1  pipeline advance this cycle (global stall low); consumes held results.
- i_read  in  1  instruction read request.
- i_addr  in  ADDR_WIDTH  instruction physical address.
- i_mask  in  MASK_WIDTH  instruction byte mask.
- i_rdata  out  DATA_WIDTH  instruction read data.
- i_stall  out  1  instruction master stall.
- d_read  in  1  data read request.
- d_write  in  1  data write request.
- d_addr  in  ADDR_WIDTH  data physical address.
- d_mask  in  MASK_WIDTH  data byte mask.
- d_wdata  in  DATA_WIDTH  write data.
- d_rdata  out  DATA_WIDTH  data read data.
- d_stall  out  1  data master stall.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  ADDR_WIDTH  memory address, registered.
- mem_mask  out  MASK_WIDTH  memory byte mask, registered.
- mem_wdata  out  DATA_WIDTH  memory write data, registered.
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse, any latency ≥0 cycles after mem_req rises.

Behaviour:
- Request definition: i_req = i_read; d_req = d_read | d_write. d_read and d_write both high is treated as a write.
- Per-master state: done_i / done_d flag plus held rdata register.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Pending set: d_req & ~done_d, and i_req & ~done_i.
  - Data has priority. Winner's addr/mask/wdata/we are latched into mem_* and the FSM moves to BUSY_x.
  - mem_req=1 from the next cycle. Nothing pending -> stay IDLE, mem_req=0.
- BUSY_x:
  - mem_* held constant while mem_ack=0.
  - On mem_ack: mem_req drops the next cycle and the FSM returns to IDLE. No back-to-back issue; minimum 2 cycles per access, and IDLE re-arbitrates the cycle after.
- Read data path:
  - Ack cycle: x_rdata = mem_rdata combinationally.
  - done_x set and rdata held, unless adv=1 that same cycle (result consumed immediately).
  - Writes return 0 as rdata.
- Stall: x_stall = x_req & ~done_x & ~(BUSY_x & mem_ack).
  - While done_x=1: x_stall=0 and x_rdata = held value.
  - Otherwise x_rdata = 0 outside the ack cycle.
- adv=1 clears both done flags at the clock edge.
- Simultaneous i_req and d_req from IDLE: data served first, then instruction. Both stall until each completes; done_d keeps the data access from being repeated.
- Request dropped while BUSY_x (flush): access still completes to memory, the result is discarded and done_x is not set.
- mem_ack in IDLE: ignored.
- Reset:
  - State IDLE, mem_req=0, mem_we=0, mem_addr/mask/wdata=0, done flags=0, held rdata=0.
  - Outputs i_stall/d_stall follow the stall equation, so they are 0 with no requests. i_rdata/d_rdata=0.
  - Reset mid-access abandons it; a later stray mem_ack is ignored.

Test Plan:
- Single instruction read, mem_ack 1 cycle after mem_req, i_addr=0x0000_1000, mem_rdata=0x2402_0005:
  - i_stall high until the ack cycle; i_rdata=0x2402_0005 on that cycle.
  - mem_req=0 the next cycle.
- Concurrent d_write (addr 0x80, mask 4'b0011, wdata 0xDEAD_BEEF) and i_read (0x1004), adv held 0:
  - Write issued first with mem_we=1, mem_mask=4'b0011.
  - After its ack, d_stall=0 and no second write occurs; instruction read then issues.
  - Raise adv after i ack -> done flags clear.
- Held result: d_read ack with mem_rdata=0x1234_5678 while i still stalls:
  - d_rdata stays 0x1234_5678 for every cycle until adv=1, then returns to 0.
- Latency 0: mem_ack in the first mem_req cycle -> completion handled; IDLE next cycle.
- Flush: drop i_read while BUSY_I -> access completes, done_i stays 0, i_stall=0, no reissue.
- Reset mid-access: rst=1 in BUSY_D -> next cycle IDLE, mem_req=0; stray mem_ack afterwards ignored, no done flag set.
